// File: rtl/dram_rsp_pkg.sv
// Purpose: shared widths, last-flag position and burst FSM state type for the DRAM response return path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_rsp_pkg;

   localparam int OUT_FIFO_WIDTH = 65;
   localparam int DATA_W         = 64;
   localparam int MAX_BEATS      = 8;
   localparam int LAST_BIT       = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

endpackage

// File: rtl/rsp_skid_buf.sv
// Purpose: 2-entry skid buffer between the response FIFO head and the host valid/ready port.
// Latency: 1 cycle from FIFO pop to out_vld when empty; one entry per cycle sustained.
// Backpressure: stops popping once both entries are full; the head entry holds while out_rdy is low.
module rsp_skid_buf
   import dram_rsp_pkg::*;
#(
   parameter int WIDTH = OUT_FIFO_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_ren,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat
);

   logic [1:0]       occ_q, occ_d;
   logic [WIDTH-1:0] ent0_q, ent0_d;
   logic [WIDTH-1:0] ent1_q, ent1_d;
   logic             accept;
   logic [1:0]       slot;

   // Pop only when there is room; the reset term keeps the FIFO untouched while rst is high.
   assign fifo_ren = !fifo_empty && (occ_q < 2'd2) && !rst;
   assign out_vld  = (occ_q != 2'd0) && !rst;
   assign out_dat  = rst ? '0 : ent0_q;
   assign accept   = out_vld && out_rdy;
   // Slot the incoming entry lands in, after any same-cycle shift from the accept.
   assign slot     = occ_q - {1'b0, accept};

   // Next entries/occupancy: shift on accept, then write the popped entry behind the survivors.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q + {1'b0, fifo_ren} - {1'b0, accept};
      if (accept) begin
         ent0_d = ent1_q;
      end
      if (fifo_ren) begin
         if (slot == 2'd0) begin
            ent0_d = fifo_data;
         end else begin
            ent1_d = fifo_data;
         end
      end
   end

   // Entry and occupancy registers; reset discards anything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= 2'd0;
         ent0_q <= '0;
         ent1_q <= '0;
      end else begin
         occ_q  <= occ_d;
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
      end
   end

endmodule

// File: rtl/rsp_return_ctrl.sv
// Purpose: returns DRAM read beats to the host, tracking beat index, burst count and over-length bursts.
// Latency: 1 cycle from FIFO pop to rsp_valid; one beat per cycle sustained.
// Backpressure: rsp_ready low holds the current beat and stops FIFO pops once the skid buffer fills.
module rsp_return_ctrl #(
   parameter int OUT_FIFO_WIDTH = dram_rsp_pkg::OUT_FIFO_WIDTH,
   parameter int DATA_W         = dram_rsp_pkg::DATA_W,
   parameter int MAX_BEATS      = dram_rsp_pkg::MAX_BEATS,
   localparam int BEAT_W        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fifo_empty,
   input  logic [OUT_FIFO_WIDTH-1:0] fifo_data,
   output logic                      fifo_ren,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_last,
   output logic [BEAT_W-1:0]         rsp_beat,
   output logic [15:0]               burst_cnt,
   output logic                      err_overlen
);

   import dram_rsp_pkg::*;

   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS - 1);

   logic [OUT_FIFO_WIDTH-1:0] head;
   logic                      accept;
   logic                      head_flag;

   state_e            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [15:0]       burst_q, burst_d;
   logic              err_q, err_d;

   rsp_skid_buf #(
      .WIDTH (OUT_FIFO_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_ren   (fifo_ren),
      .out_vld    (rsp_valid),
      .out_rdy    (rsp_ready),
      .out_dat    (head)
   );

   assign head_flag   = head[LAST_BIT];
   assign accept      = rsp_valid && rsp_ready;
   assign rsp_data    = head[DATA_W-1:0];
   // A burst closes on the FIFO's own flag or when the index hits the ceiling.
   assign rsp_last    = rsp_valid && (head_flag || (beat_q == BEAT_MAX));
   assign rsp_beat    = rst ? '0 : beat_q;
   assign burst_cnt   = rst ? 16'd0 : burst_q;
   assign err_overlen = err_q && !rst;

   // Burst tracking: advance the index on each accepted beat, close the burst on an accepted last.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      err_d   = err_q;
      if (accept) begin
         if (rsp_last) begin
            state_d = IDLE;
            beat_d  = '0;
            burst_d = burst_q + 16'd1;
            if (!head_flag) begin
               err_d = 1'b1;
            end
         end else begin
            state_d = BURST;
            beat_d  = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // State, index and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         burst_q <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_rsp_return_ctrl.sv
// Purpose: self-checking bench for rsp_return_ctrl with a FIFO model and an expected-beat scoreboard.
// Latency: n/a.
// Backpressure: drives rsp_ready and FIFO-empty stalls from directed and random patterns.
module tb_rsp_return_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [64:0] fifo_data;
   logic        fifo_ren;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_last;
   logic [2:0]  rsp_beat;
   logic [15:0] burst_cnt;
   logic        err_overlen;

   rsp_return_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_ren    (fifo_ren),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_last    (rsp_last),
      .rsp_beat    (rsp_beat),
      .burst_cnt   (burst_cnt),
      .err_overlen (err_overlen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic [2:0]  b;
      logic        f;
   } exp_t;

   logic [64:0] fq[$];
   exp_t        sb[$];
   int          acc_cyc[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          idx_m = 0;
   logic [15:0] bursts_m = 16'd0;
   logic        err_m = 1'b0;
   logic        stall = 1'b0;
   bit          rnd_mode = 1'b0;
   int          gen_single = 0;
   int          pops_cnt = 0;
   int          acc_total = 0;
   int          first_ren_cyc = -1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic push_beat(input logic [63:0] d, input logic l64);
      exp_t e;
      e.d = d;
      e.f = !l64 && (idx_m == 7);
      e.l = l64 || (idx_m == 7);
      e.b = 3'(idx_m);
      fq.push_back({l64, d});
      sb.push_back(e);
      idx_m = e.l ? 0 : idx_m + 1;
   endtask

   task automatic drive_inputs();
      fifo_empty = (fq.size() == 0) || stall;
      fifo_data  = (fq.size() != 0) ? fq[0] : 65'd0;
   endtask

   task automatic step();
      logic ren_s;
      logic acc;
      exp_t e;
      @(negedge clk);
      if (fifo_empty) chk("ren_when_empty", 64'(fifo_ren), 64'd0);
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 64'(rsp_valid), 64'd0);
         end else begin
            chk("data", rsp_data, sb[0].d);
            chk("last", 64'(rsp_last), 64'(sb[0].l));
            chk("beat", 64'(rsp_beat), 64'(sb[0].b));
         end
      end
      ren_s = fifo_ren;
      acc   = rsp_valid && rsp_ready;
      if (ren_s) begin
         pops_cnt++;
         if (first_ren_cyc < 0) first_ren_cyc = cyc;
      end
      if (acc) begin
         acc_total++;
         acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ren_s && fq.size() > 0) void'(fq.pop_front());
      if (acc && sb.size() > 0) begin
         e = sb.pop_front();
         if (e.l) bursts_m = bursts_m + 16'd1;
         if (e.f) err_m = 1'b1;
      end
      if (gen_single > 0 && fq.size() < 3) begin
         push_beat(rand64(), 1'b1);
         gen_single--;
      end
      if (rnd_mode) begin
         stall     = ($urandom_range(0, 3) == 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (fq.size() < 6 && $urandom_range(0, 1) == 1)
            push_beat(rand64(), ($urandom_range(0, 3) == 0));
      end
      drive_inputs();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((sb.size() > 0 || fq.size() > 0 || gen_single > 0) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_outs_zero(input string pfx);
      chk({pfx, "_valid"}, 64'(rsp_valid), 64'd0);
      chk({pfx, "_ren"},   64'(fifo_ren), 64'd0);
      chk({pfx, "_data"},  rsp_data, 64'd0);
      chk({pfx, "_last"},  64'(rsp_last), 64'd0);
      chk({pfx, "_beat"},  64'(rsp_beat), 64'd0);
      chk({pfx, "_bcnt"},  64'(burst_cnt), 64'd0);
      chk({pfx, "_err"},   64'(err_overlen), 64'd0);
   endtask

   // Entered and left at posedge+1; clears the FIFO model and scoreboard alongside the DUT.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk_outs_zero("in_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      fq.delete();
      sb.delete();
      idx_m    = 0;
      bursts_m = 16'd0;
      err_m    = 1'b0;
      drive_inputs();
      @(negedge clk);
      chk_outs_zero("post_rst");
      @(posedge clk);
      #1;
      cyc = cyc + 2;
   endtask

   initial begin
      #1_200_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a non-empty FIFO: no pops and all outputs zero.
      rst        = 1'b1;
      rsp_ready  = 1'b0;
      fifo_empty = 1'b0;
      fifo_data  = {1'b1, rand64()};
      repeat (2) begin
         @(negedge clk);
         chk_outs_zero("reset");
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_inputs();

      // Four-beat burst, back to back, one cycle after the first pop.
      rsp_ready     = 1'b1;
      first_ren_cyc = -1;
      acc_cyc.delete();
      for (int i = 0; i < 4; i++) push_beat(rand64(), (i == 3));
      drive_inputs();
      drain("drain_4beat", 50);
      chk("b2b_count", 64'(acc_cyc.size()), 64'd4);
      if (acc_cyc.size() == 4)
         for (int i = 0; i < 4; i++)
            chk("b2b_cycle", 64'(acc_cyc[i]), 64'(first_ren_cyc + 1 + i));
      chk("bcnt_4beat", 64'(burst_cnt), 64'd1);

      // Host stalled for 5 cycles with 3 entries queued.
      rsp_ready = 1'b0;
      pops_cnt  = 0;
      for (int i = 0; i < 3; i++) push_beat(rand64(), (i == 2));
      drive_inputs();
      repeat (5) step();
      chk("stall_pops", 64'(pops_cnt), 64'd2);
      chk("stall_ren_low", 64'(fifo_ren), 64'd0);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      drain("drain_stall", 50);
      chk("bcnt_stall", 64'(burst_cnt), 64'd2);
      chk("err_clean", 64'(err_overlen), 64'd0);

      // Ten-beat burst: forced last at index 7, remaining beats open a new burst.
      for (int i = 0; i < 10; i++) push_beat(rand64(), (i == 9));
      drive_inputs();
      drain("drain_overlen", 100);
      chk("err_overlen", 64'(err_overlen), 64'd1);
      chk("bcnt_overlen", 64'(burst_cnt), 64'd4);
      chk("bcnt_model", 64'(burst_cnt), 64'(bursts_m));

      // Reset after the second beat of a four-beat burst.
      acc_total = 0;
      for (int i = 0; i < 4; i++) push_beat(rand64(), (i == 3));
      drive_inputs();
      for (int n = 0; n < 20 && acc_total < 2; n++) step();
      chk("pre_rst_beats", 64'(acc_total), 64'd2);
      do_reset();
      for (int i = 0; i < 2; i++) push_beat(rand64(), (i == 1));
      drive_inputs();
      drain("drain_post_rst", 50);
      chk("bcnt_post_rst", 64'(burst_cnt), 64'd1);

      // 65536 single-beat bursts wrap the burst counter to zero.
      do_reset();
      gen_single = 65536;
      drive_inputs();
      drain("drain_wrap", 70000);
      chk("bcnt_wrap", 64'(burst_cnt), 64'd0);
      chk("err_wrap", 64'(err_overlen), 64'd0);

      // Random FIFO-empty and host-ready patterns.
      rnd_mode = 1'b1;
      repeat (10000) step();
      rnd_mode  = 1'b0;
      stall     = 1'b0;
      rsp_ready = 1'b1;
      drive_inputs();
      drain("drain_random", 500);
      chk("bcnt_random", 64'(burst_cnt), 64'(bursts_m));
      chk("err_random", 64'(err_overlen), 64'(err_m));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rsp_return_ctrl.md
RSP_RETURN_CTRL -- requirements
Module: rsp_return_ctrl

Interface
REQ-001 Parameter OUT_FIFO_WIDTH, default 65, SHALL set the response FIFO entry width: bit 64 is the last-beat flag and bits 63:0 are read data.
REQ-002 Parameter DATA_W, default 64, SHALL set the return data width.
REQ-003 Parameter MAX_BEATS, default 8, SHALL set the maximum number of beats per burst.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset; reset is synchronous and active-high.
REQ-006 Port fifo_empty, input, 1 bit, SHALL be the response FIFO empty flag.
REQ-007 Port fifo_data, input, OUT_FIFO_WIDTH bits, SHALL be the FIFO head entry, valid in the same cycle whenever fifo_empty=0.
REQ-008 Port fifo_ren, output, 1 bit, SHALL be the FIFO pop strobe; a high cycle consumes the head entry.
REQ-009 Port rsp_valid, output, 1 bit, SHALL flag that a return beat is valid toward the host.
REQ-010 Port rsp_ready, input, 1 bit, SHALL be the host accept signal.
REQ-011 Port rsp_data, output, DATA_W bits, SHALL carry the return beat data.
REQ-012 Port rsp_last, output, 1 bit, SHALL mark the final beat of a burst.
REQ-013 Port rsp_beat, output, clog2(MAX_BEATS) bits, SHALL give the beat index within the current burst.
REQ-014 Port burst_cnt, output, 16 bits, SHALL count completed bursts.
REQ-015 Port err_overlen, output, 1 bit, SHALL be a sticky flag for an over-length burst.

Function
REQ-016 The block SHALL hold entries in a 2-entry skid buffer with occupancy occ in the range 0..2.
REQ-017 fifo_ren SHALL be driven as (!fifo_empty && occ<2 && !rst) and SHALL never assert while fifo_empty=1.
REQ-018 A beat popped in cycle N with occ=0 SHALL appear with rsp_valid=1 in cycle N+1 (1-cycle latency).
REQ-019 A beat SHALL be accepted only in a cycle where rsp_valid && rsp_ready are both high.
REQ-020 occ SHALL be updated each cycle as occ + fifo_ren - accept.
REQ-021 With occ=1, continuous input and rsp_ready held at 1, the block SHALL sustain one beat per cycle.
REQ-022 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_last and rsp_beat SHALL hold stable.
REQ-023 Beats SHALL leave in FIFO order; no beat SHALL be dropped or duplicated.
REQ-024 The FSM SHALL have two states: IDLE, meaning the beat counter is 0 and no burst is open, and BURST, meaning a burst is open.
REQ-025 On accepting a beat with rsp_last=0, the FSM SHALL go to BURST and increment the beat counter.
REQ-026 On accepting a beat with rsp_last=1, the FSM SHALL go to IDLE, clear the beat counter and increment burst_cnt.
REQ-027 rsp_last SHALL equal (head entry bit 64) OR (rsp_beat == MAX_BEATS-1).
REQ-028 When rsp_last is forced by beat index alone (bit 64 = 0), err_overlen SHALL set on acceptance of that beat and remain set until reset.
REQ-029 Following beats after a forced last SHALL start a new burst at index 0.
REQ-030 burst_cnt SHALL wrap modulo 2^16 (0xFFFF+1 -> 0x0000) and SHALL not saturate.
REQ-031 If a pop and an accept occur in the same cycle at occ=2, this SHALL be impossible by REQ-017; at occ=1 occupancy SHALL stay 1.

Reset
REQ-032 While rst=1, the outputs SHALL be: occ=0, rsp_valid=0, fifo_ren=0, rsp_data=0, rsp_last=0, rsp_beat=0, burst_cnt=0, err_overlen=0, and the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-burst SHALL discard buffered beats; the first post-reset beat SHALL have rsp_beat=0.
REQ-034 fifo_ren SHALL first assert no earlier than the first cycle after rst deasserts.

Structure
REQ-035 The shared package dram_rsp_pkg SHALL hold OUT_FIFO_WIDTH, DATA_W, MAX_BEATS, the last-flag bit index and the state enum {IDLE, BURST}.
REQ-036 The skid buffer SHALL be implemented as the sub-module rsp_skid_buf, which carries the pop/accept and occupancy logic; burst tracking SHALL reside in rsp_return_ctrl.

Verification
REQ-037 Scenario: FIFO holds 4 beats, the last with bit 64=1, and rsp_ready=1 -> 4 beats on 4 consecutive cycles starting one cycle after the first fifo_ren, rsp_beat 0..3, rsp_last only on beat 3, burst_cnt=1.
REQ-038 Scenario: rsp_ready=0 for 5 cycles with 3 entries queued -> exactly 2 pops then fifo_ren=0, rsp_data stable; on rsp_ready=1, all 3 beats return in order.
REQ-039 Scenario: a burst of 10 beats with bit 64 only on beat 9 -> rsp_last on beat 7, err_overlen=1, beats 8..9 output with rsp_beat 0..1, burst_cnt=2.
REQ-040 Scenario: burst_cnt preset by running 65536 single-beat bursts -> burst_cnt reads 0x0000 with no error.
REQ-041 Scenario: rst pulsed for 1 cycle after beat 2 of a 4-beat burst -> all outputs 0 in the following cycle, and the next beat shows rsp_beat=0.
REQ-042 Scenario: random fifo_empty and rsp_ready patterns over 10k cycles -> scoreboard shows in-order, lossless delivery and no fifo_ren while fifo_empty=1.
